// File: rtl/cc_pkg.sv
// Shared types and constants for the LC-3 condition-code unit.
// Latency: n/a (types, constants, pure functions only).
// Backpressure: n/a.
package cc_pkg;

  // Condition codes packed as {N,Z,P}
  typedef logic [2:0] cc_t;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  // Bit positions inside the sticky error vector
  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_CONF = 2;

  localparam cc_t CC_RESET = 3'b010;

  // One-hot {N,Z,P} from the sign bit and an all-zero indication
  function automatic cc_t cc_from_bits(input logic neg, input logic zero);
    cc_t r;
    r       = '0;
    r[CC_N] = neg;
    r[CC_Z] = zero;
    r[CC_P] = ~neg & ~zero;
    return r;
  endfunction

endpackage

// File: rtl/cc_stack.sv
// DEPTH x 3 LIFO saving condition codes across nested interrupts.
// Latency: push/pop take effect at the next edge; dout shows the top entry combinationally.
// Backpressure: none; push when full and pop when empty are ignored (caller flags them).
module cc_stack
  import cc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  cc_t           din,
  output cc_t           dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t           mem [DEPTH];
  logic          do_push;
  logic          do_pop;
  logic [DW-1:0] depth_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  // A simultaneous push and pop is a no-op for the stack itself
  assign do_push  = push & ~pop & ~full;
  assign do_pop   = pop & ~push & ~empty;
  assign depth_m1 = depth - DW'(1);
  assign wr_idx   = depth[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];
  assign dout     = mem[rd_idx];

  // Occupancy counter; reset discards any saved entries
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
    end else if (do_push) begin
      depth <= depth + DW'(1);
    end else if (do_pop) begin
      depth <= depth_m1;
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/nzp_cc_unit.sv
// LC-3 condition-code unit: NZP derivation, PSR load, save stack, BR evaluation.
// Latency: flags, stack, errors and branch decision all update one cycle after the request.
// Backpressure: none; illegal stack requests are dropped and recorded in sticky err bits.
module nzp_cc_unit
  import cc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             Buss,
  input  logic                         flagWE,
  input  logic                         ld_cc,
  input  logic [2:0]                   cc_in,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  input  logic                         br_valid,
  input  logic [2:0]                   br_mask,
  output logic                         N,
  output logic                         Z,
  output logic                         P,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stk_full,
  output logic                         stk_empty,
  output logic [2:0]                   err,
  output logic                         br_taken,
  output logic                         br_done
);

  localparam int DW = $clog2(DEPTH + 1);

  cc_t        cc_q;
  cc_t        cc_d;
  cc_t        derived;
  cc_t        stk_top;
  logic       pop_win;
  logic [2:0] err_set;

  assign derived = cc_from_bits(Buss[WIDTH-1], Buss == '0);
  // pop only restores when it is alone and there is something to restore
  assign pop_win = pop & ~push & ~stk_empty;

  cc_stack #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cc_q),
    .dout  (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-CC priority: stack restore, then PSR load, then bus derivation
  always_comb begin
    cc_d = cc_q;
    if (pop_win) begin
      cc_d = stk_top;
    end else if (ld_cc) begin
      cc_d = cc_in;
    end else if (flagWE) begin
      cc_d = derived;
    end
  end

  // Error conditions raised by this cycle's stack requests
  always_comb begin
    err_set           = '0;
    err_set[ERR_CONF] = push & pop;
    err_set[ERR_UNF]  = pop & ~push & stk_empty;
    err_set[ERR_OVF]  = push & ~pop & stk_full;
  end

  // Condition-code register
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  // Sticky errors; a new event in the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else begin
      err <= (err_clr ? 3'b000 : err) | err_set;
    end
  end

  // Branch decision from pre-edge flags
  always_ff @(posedge clk) begin
    if (reset) begin
      br_taken <= 1'b0;
      br_done  <= 1'b0;
    end else begin
      br_taken <= |(br_mask & cc_q);
      br_done  <= br_valid;
    end
  end

  assign N = cc_q[CC_N];
  assign Z = cc_q[CC_Z];
  assign P = cc_q[CC_P];

endmodule
